ahbl_uart_tx: RTL and testbench
===============================

Name: ahbl_uart_tx

Overview:
- AHB-Lite slave UART transmitter with a TX FIFO.
- The CPU pushes bytes through a DATA register. A built-in 8N1 serializer drains the FIFO onto `tx`.
- Replaces the GPIO-change-triggered UART path in the SoC. It hangs off a free splitter slot (S3, 0x8000_0000) and feeds the board TX pin.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- DEFAULT_DIV, 624, reset value of BAUDDIV; bit period = BAUDDIV+1 HCLK cycles.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from splitter
- HADDR  in  32  address; only [3:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 means active
- HSIZE  in  3  ignored; all accesses treated as 32-bit
- HWRITE  in  1  write/read
- HREADY  in  1  bus ready
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  tied 1 (zero wait states)
- HRDATA  out  32  read data
- tx  out  1  serial output; idle high
- irq  out  1  level: EN & FIFO empty & serializer idle

Behaviour:
- Reset values:
  - tx=1, HRDATA=0, irq=0.
  - FIFO empty, state IDLE, CTRL.EN=0, BAUDDIV=DEFAULT_DIV, OVR=0.
- Reset mid-frame: tx returns high immediately (async) and the FIFO is cleared.
- Bus address phase:
  - Latch HADDR[3:2], HWRITE and valid when HSEL & HREADY & HTRANS[1].
  - The write takes effect on the data-phase clock edge using HWDATA.
- Register map (HADDR[3:2]):
  - 0 DATA:
    - Write pushes HWDATA[7:0] into the FIFO.
    - Read returns 0.
  - 1 STATUS, read:
    - bit0 FULL, bit1 EMPTY, bit2 BUSY (state != IDLE), bit3 OVR.
    - bits[15:8] FIFO level (0..FIFO_DEPTH).
  - 1 STATUS, write: writing 1 to bit3 clears OVR; other bits are ignored.
  - 2 CTRL: bit0 EN, read/write; other bits read 0.
  - 3 BAUDDIV: bits[15:0], read/write. A new value takes effect at the next bit boundary.
- HRDATA:
  - Combinational from the latched address and current state.
  - Data-phase read of STATUS reflects state before that edge's updates.
- FIFO pointers and level:
  - Circular buffer; read and write pointers wrap at FIFO_DEPTH.
  - Level counter is log2(FIFO_DEPTH)+1 bits.
- Push while FULL:
  - The byte is dropped and OVR is set (sticky).
  - Exception: if a pop occurs on the same edge, the push is accepted and the level is unchanged.
- Push and pop on the same edge when not full: level unchanged; data order preserved (FIFO).
- Serializer FSM:
  - IDLE: tx=1. If EN & !EMPTY, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for BAUDDIV+1 cycles, then DATA with bit index 0.
  - DATA:
    - tx=shift[0] (LSB first).
    - After each BAUDDIV+1 cycles, shift right and increment the index.
    - After the 8th bit, go to STOP.
  - STOP: tx=1 for BAUDDIV+1 cycles, then IDLE.
- Frame timing:
  - Frame length = 10*(BAUDDIV+1) cycles.
  - The start bit appears on tx one cycle after the pop edge.
  - Back-to-back frames are separated by exactly one IDLE cycle.
- Baud counter: counts 0..BAUDDIV, 16-bit. BAUDDIV=0 gives a 1-cycle bit.
- EN cleared mid-frame: the current frame completes; no further pops. Bytes remain in the FIFO.
- Clearing OVR and a new overflow on the same cycle: set wins.

Test Plan:
- Reset:
  - Drive HRESETn=0 mid-frame -> tx=1 immediately.
  - After release, STATUS reads 0x0000_0002; BAUDDIV reads 624.
- Single byte:
  - BAUDDIV=3, EN=1, write DATA=0xA5.
  - tx sequence is 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit (start, LSB-first data, stop); total 40 cycles.
  - irq goes high afterwards.
- Fill and overflow (EN=0):
  - Write 9 bytes -> STATUS level=8, FULL=1, OVR=1.
  - Write 0x8 to STATUS -> OVR=0.
- Drain order:
  - FIFO holds 0x01..0x08, set EN=1, BAUDDIV=0.
  - Eight 10-cycle frames in order 0x01..0x08, each separated by 1 idle cycle; then EMPTY=1, BUSY=0.
- Push while full on a pop edge: the FIFO is full and a push lands on the pop edge -> byte accepted, OVR stays 0, level stays 8.
- EN drop: clear EN during frame 1 of 3 -> frame 1 completes, tx stays high, level=2.

Source files
------------

// File: rtl/ahbl_uart_tx.sv
// AHB-Lite slave UART transmitter: DATA/STATUS/CTRL/BAUDDIV registers, TX FIFO and 8N1 serializer.
// Zero-wait-state slave; writes commit on the data-phase clock edge.
module ahbl_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 624
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Address-phase capture
  logic       r_valid;
  logic       r_write;
  logic [1:0] r_addr;

  // Control/status registers
  logic        r_en;
  logic        r_ovr;
  logic [15:0] r_baud;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  // Serializer
  state_e      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitidx;
  logic [15:0] r_cnt;
  logic [15:0] r_div;
  logic        r_tx;

  state_e      w_state_d;
  logic [7:0]  w_shift_d;
  logic [2:0]  w_bitidx_d;
  logic [15:0] w_cnt_d;
  logic [15:0] w_div_d;
  logic        w_tx_d;
  logic        w_pop;
  logic        w_tick;

  logic w_wr;
  logic w_rd;
  logic w_push;
  logic w_push_ok;
  logic w_ovf;
  logic w_ovr_clr;
  logic w_full;
  logic w_empty;
  logic w_busy;
  logic [7:0] w_level8;
  logic w_unused;

  assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 2'd0;
    end else begin
      r_valid <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        r_write <= HWRITE;
        r_addr  <= HADDR[3:2];
      end
    end
  end

  assign w_wr      = r_valid & r_write;
  assign w_rd      = r_valid & ~r_write;
  assign w_push    = w_wr & (r_addr == 2'd0);
  assign w_ovr_clr = w_wr & (r_addr == 2'd1) & HWDATA[3];

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_busy    = (r_state != StIdle);
  assign w_level8  = 8'(r_level);

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf     = w_push & w_full & ~w_pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_en   <= 1'b0;
      r_ovr  <= 1'b0;
      r_baud <= 16'(DEFAULT_DIV);
    end else begin
      if (w_wr && r_addr == 2'd2) r_en <= HWDATA[0];
      if (w_wr && r_addr == 2'd3) r_baud <= HWDATA[15:0];
      if (w_ovf) begin
        r_ovr <= 1'b1;
      end else if (w_ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push_ok) r_mem[r_wptr] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push_ok && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_bitidx <= '0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_bitidx <= w_bitidx_d;
      r_cnt    <= w_cnt_d;
      r_div    <= w_div_d;
      r_tx     <= w_tx_d;
    end
  end

  // r_div holds the divider for the bit in flight; BAUDDIV is resampled only at bit boundaries.
  assign w_tick = (r_cnt == r_div);

  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_bitidx_d = r_bitidx;
    w_cnt_d    = r_cnt;
    w_div_d    = r_div;
    w_pop      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_en && !w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = r_mem[r_rptr];
          w_cnt_d   = '0;
          w_div_d   = r_baud;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_cnt_d    = '0;
          w_div_d    = r_baud;
          w_bitidx_d = 3'd0;
          w_state_d  = StData;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StData: begin
        if (w_tick) begin
          w_cnt_d    = '0;
          w_div_d    = r_baud;
          w_shift_d  = {1'b0, r_shift[7:1]};
          w_bitidx_d = r_bitidx + 3'd1;
          if (r_bitidx == 3'd7) w_state_d = StStop;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StStop: begin
        if (w_tick) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Line level follows the next state so the pin is a clean register output.
    unique case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  assign tx  = r_tx;
  assign irq = r_en & w_empty & ~w_busy;

  always_comb begin
    HRDATA = '0;
    if (w_rd) begin
      unique case (r_addr)
        2'd0: HRDATA = '0;
        2'd1: HRDATA = {16'd0, w_level8, 4'd0, r_ovr, w_busy, w_empty, w_full};
        2'd2: HRDATA = {31'd0, r_en};
        2'd3: HRDATA = {16'd0, r_baud};
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_uart_tx.sv
// Self-checking bench for ahbl_uart_tx: directed AHB accesses plus a serial-line monitor
// that decodes frames and compares them against a byte scoreboard.
module tb_ahbl_uart_tx;

  localparam logic [31:0] ADDR_DATA   = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_CTRL   = 32'h8000_0008;
  localparam logic [31:0] ADDR_BAUD   = 32'h8000_000C;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        tx;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          rx_count = 0;
  bit          mon_en = 1'b0;
  int unsigned bit_p = 625;
  logic [7:0]  sb[$];
  int unsigned starts[$];

  ahbl_uart_tx #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(624)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),
    .HREADY   (HREADY),
    .HWDATA   (HWDATA),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    d = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int n = 0;
    while (rx_count < target && n < budget) begin
      @(posedge HCLK); #1;
      n++;
    end
    check(tag, 32'(rx_count), 32'(target));
  endtask

  // Line monitor: sample mid-bit on the falling clock edge and score each decoded frame.
  always begin
    @(negedge HCLK);
    if (mon_en && HRESETn && tx === 1'b0) begin
      logic [7:0]  b;
      logic        stop;
      int unsigned pp;
      pp = bit_p;
      starts.push_back(cyc);
      repeat ((pp - 1) / 2) @(negedge HCLK);
      for (int k = 0; k < 8; k++) begin
        repeat (pp) @(negedge HCLK);
        b[k] = tx;
      end
      repeat (pp) @(negedge HCLK);
      stop = tx;
      check("stop_bit", 32'(stop), 32'd1);
      check("frame_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("rx_byte", 32'(b), 32'(sb.pop_front()));
      rx_count++;
      repeat (pp - 1 - (pp - 1) / 2) @(negedge HCLK);
    end
  end

  initial begin
    int rx0;
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HSIZE   = 3'b010;
    HADDR   = '0;
    HWDATA  = '0;
    bus_idle();

    // Reset values
    repeat (3) @(posedge HCLK); #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    read_check("rst_status", ADDR_STATUS, 32'h0000_0002);
    read_check("rst_baud", ADDR_BAUD, 32'd624);

    // Async reset in the middle of a start bit, with a byte still queued
    ahb_write(ADDR_BAUD, 32'd3);
    ahb_write(ADDR_CTRL, 32'd1);
    ahb_write(ADDR_DATA, 32'h55);
    ahb_write(ADDR_DATA, 32'h66);
    check("midframe_tx_low", 32'(tx), 32'd0);
    HRESETn = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(tx), 32'd1);
    #4;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    read_check("post_rst_status", ADDR_STATUS, 32'h0000_0002);
    read_check("post_rst_baud", ADDR_BAUD, 32'd624);
    read_check("post_rst_ctrl", ADDR_CTRL, 32'd0);

    // Single byte at 4 cycles per bit
    ahb_write(ADDR_BAUD, 32'd3);
    bit_p  = 4;
    mon_en = 1'b1;
    ahb_write(ADDR_CTRL, 32'd1);
    sb.push_back(8'hA5);
    ahb_write(ADDR_DATA, 32'hA5);
    wait_rx(1, 200, "single_rx_timeout");
    repeat (6) @(posedge HCLK); #1;
    check("single_irq", 32'(irq), 32'd1);
    read_check("single_status", ADDR_STATUS, 32'h0000_0002);

    // Fill past full with EN=0, then clear OVR
    ahb_write(ADDR_CTRL, 32'd0);
    check("en0_irq", 32'(irq), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back(8'(i));
      ahb_write(ADDR_DATA, 32'(i));
    end
    read_check("ovf_status", ADDR_STATUS, 32'h0000_0809);
    ahb_write(ADDR_STATUS, 32'h8);
    read_check("ovr_clr_status", ADDR_STATUS, 32'h0000_0801);
    read_check("data_reads_zero", ADDR_DATA, 32'd0);

    // Drain at one cycle per bit; frames start 11 cycles apart
    ahb_write(ADDR_BAUD, 32'd0);
    bit_p = 1;
    starts.delete();
    rx0 = rx_count;
    ahb_write(ADDR_CTRL, 32'd1);
    wait_rx(rx0 + 8, 400, "drain_rx_timeout");
    repeat (4) @(posedge HCLK); #1;
    check("drain_frames", 32'(starts.size()), 32'd8);
    for (int i = 1; i < starts.size(); i++) begin
      check("frame_gap", starts[i] - starts[i-1], 32'd11);
    end
    read_check("drain_status", ADDR_STATUS, 32'h0000_0002);

    // Push into a full FIFO on the same edge as the first pop
    ahb_write(ADDR_CTRL, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'(8'h10 + i));
      ahb_write(ADDR_DATA, 32'(8'h10 + i));
    end
    read_check("full_status", ADDR_STATUS, 32'h0000_0801);
    rx0 = rx_count;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = ADDR_CTRL;
    @(posedge HCLK); #1;
    HADDR  = ADDR_DATA;
    HWDATA = 32'd1;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = 32'h18;
    sb.push_back(8'h18);
    @(posedge HCLK); #1;
    read_check("popedge_status", ADDR_STATUS, 32'h0000_0805);
    wait_rx(rx0 + 9, 400, "popedge_rx_timeout");
    repeat (4) @(posedge HCLK); #1;
    read_check("popedge_drained", ADDR_STATUS, 32'h0000_0002);

    // Drop EN during the first of three frames
    ahb_write(ADDR_CTRL, 32'd0);
    ahb_write(ADDR_BAUD, 32'd3);
    bit_p = 4;
    ahb_write(ADDR_DATA, 32'h31);
    ahb_write(ADDR_DATA, 32'h32);
    ahb_write(ADDR_DATA, 32'h33);
    sb.push_back(8'h31);
    rx0 = rx_count;
    ahb_write(ADDR_CTRL, 32'd1);
    repeat (8) @(posedge HCLK); #1;
    ahb_write(ADDR_CTRL, 32'd0);
    wait_rx(rx0 + 1, 200, "endrop_rx_timeout");
    repeat (60) @(posedge HCLK); #1;
    check("endrop_tx_idle", 32'(tx), 32'd1);
    check("endrop_no_more_frames", 32'(rx_count), 32'(rx0 + 1));
    read_check("endrop_status", ADDR_STATUS, 32'h0000_0200);
    check("endrop_irq", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
